// File: rtl/glitch_detector_pkg.sv
// Shared encodings for the target-clock glitch detector.
package glitch_detector_pkg;

    typedef enum logic [1:0] {
        GL_NONE    = 2'b00,
        GL_SHORT   = 2'b01,
        GL_STRETCH = 2'b10
    } gl_kind_e;

    typedef enum logic [1:0] {
        GD_IDLE    = 2'b00,
        GD_PH_HIGH = 2'b01,
        GD_PH_LOW  = 2'b10
    } gd_state_e;

endpackage

// File: rtl/glitch_detector_sync.sv
// Two-flop synchronizer for clk_in plus one delay flop for edge detection.
module glitch_detector_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic edge_det
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign lvl      = s2_q;
    assign edge_det = s2_q ^ s3_q;

endmodule

// File: rtl/glitch_detector.sv
// Measures clk_in phase widths and flags too-short or stretched phases.
module glitch_detector
    import glitch_detector_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int GCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              clk_in,
    input  logic [CNT_W-1:0]  min_w,
    input  logic [CNT_W-1:0]  max_w,
    output logic              glitch_stb,
    output logic [1:0]        glitch_kind,
    output logic              glitch_level,
    output logic [CNT_W-1:0]  last_width,
    output logic [GCNT_W-1:0] glitch_count,
    output logic              armed
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GCNT_W-1:0] GCNT_MAX = '1;

    logic lvl, edge_det;

    glitch_detector_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .d        (clk_in),
        .lvl      (lvl),
        .edge_det (edge_det)
    );

    gd_state_e         state_q, state_d;
    gl_kind_e          kind_q, kind_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [GCNT_W-1:0] count_q, count_d;
    logic              stretch_q, stretch_d;
    logic              stb_q, stb_d;
    logic              level_q, level_d;
    logic              armed_q, armed_d;

    logic              in_ph, ev_short, ev_stretch, ev;
    logic [CNT_W:0]    cnt_inc;

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        width_d   = width_q;
        count_d   = count_q;
        stretch_d = stretch_q;
        level_d   = level_q;

        cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        in_ph   = (state_q != GD_IDLE) && en;

        // cnt holds the finished phase width during the edge cycle
        if (edge_det)
            cnt_d = CNT_W'(1);
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_inc[CNT_W-1:0];

        ev_short   = in_ph && edge_det && (cnt_q < min_w);
        ev_stretch = in_ph && !edge_det && !stretch_q
                     && (max_w > CNT_W'(1))
                     && (cnt_inc == {1'b0, max_w});
        ev         = ev_short || ev_stretch;
        stb_d      = ev;

        unique case (state_q)
            GD_IDLE: begin
                if (en && edge_det)
                    state_d = lvl ? GD_PH_HIGH : GD_PH_LOW;
            end
            GD_PH_HIGH, GD_PH_LOW: begin
                if (!en)
                    state_d = GD_IDLE;
                else if (edge_det)
                    state_d = lvl ? GD_PH_HIGH : GD_PH_LOW;
            end
            default: state_d = GD_IDLE;
        endcase

        if (in_ph && edge_det)
            width_d = cnt_q;

        if (edge_det || !in_ph)
            stretch_d = 1'b0;
        else if (ev_stretch)
            stretch_d = 1'b1;

        if (ev_short) begin
            kind_d  = GL_SHORT;
            level_d = ~lvl;
        end else if (ev_stretch) begin
            kind_d  = GL_STRETCH;
            level_d = lvl;
        end

        if (clr)
            count_d = '0;
        else if (ev && count_q != GCNT_MAX)
            count_d = count_q + GCNT_W'(1);

        armed_d = (state_d != GD_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= GD_IDLE;
            kind_q    <= GL_NONE;
            cnt_q     <= '0;
            width_q   <= '0;
            count_q   <= '0;
            stretch_q <= 1'b0;
            stb_q     <= 1'b0;
            level_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            width_q   <= width_d;
            count_q   <= count_d;
            stretch_q <= stretch_d;
            stb_q     <= stb_d;
            level_q   <= level_d;
            armed_q   <= armed_d;
        end
    end

    assign glitch_stb   = stb_q;
    assign glitch_kind  = kind_q;
    assign glitch_level = level_q;
    assign last_width   = width_q;
    assign glitch_count = count_q;
    assign armed        = armed_q;

endmodule
